dc1_xbit_upd: RTL

Write-side sequencer for the L1 data-cache speculation-bit (x-bit) array. It accepts pbit set/clear requests from the two load/store pipes and 16-bit line-insert updates from the fill path. It buffers them and drives the array's two write ports (`write0_*`, `write1_*`) plus the insert channel (`write_ins`, `write_data`). It also performs the clear-all walk after reset and on a speculation-barrier event.

---
 rtl/dc1_xbit_upd_pkg.sv | 31 +++
 rtl/dc1_xbit_fifo.sv | 60 ++++++
 rtl/dc1_xbit_upd.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dc1_xbit_upd_pkg.sv
// Shared types for the x-bit write sequencer: request record, sequencer state, array geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dc1_xbit_upd_pkg;

`ifdef DCACHE_256K
    localparam int XBIT_ADDR_WIDTH = 6;
`else
    localparam int XBIT_ADDR_WIDTH = 5;
`endif

    // Full request address width; the set index lives in [XBIT_ADDR_WIDTH+3:4].
    localparam int XBIT_REQ_AW = XBIT_ADDR_WIDTH + 5;

    typedef struct packed {
        logic [XBIT_REQ_AW-1:0] addr;
        logic                   odd;
        logic                   pbit;
    } xbit_req_t;

    typedef enum logic {
        ST_WALK = 1'b0,
        ST_RUN  = 1'b1
    } xbit_state_e;

    // Two requests hit the same array bit when set index and bank match.
    function automatic logic xbit_same_slot(xbit_req_t a, xbit_req_t b);
        return (a.addr[XBIT_ADDR_WIDTH+3:4] == b.addr[XBIT_ADDR_WIDTH+3:4]) && (a.odd == b.odd);
    endfunction

endpackage

// File: rtl/dc1_xbit_fifo.sv
// 2-push / 2-pop FIFO of x-bit requests with single-cycle flush.
// Latency: an entry pushed at edge N is visible at the head from cycle N+1.
// Backpressure: none internally; the caller must not push beyond DEPTH.
module dc1_xbit_fifo
    import dc1_xbit_upd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push0,
    input  xbit_req_t     i_push0_dat,
    input  logic          i_push1,
    input  xbit_req_t     i_push1_dat,
    input  logic [1:0]    i_pop_n,
    output xbit_req_t     o_head,
    output xbit_req_t     o_head1,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_count_nxt
);
    localparam int PW = $clog2(DEPTH);

    xbit_req_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_wr_ptr1;
    logic [PW-1:0] w_rd_ptr1;
    logic [CW-1:0] w_push_n;

    assign w_push_n    = CW'(i_push0) + CW'(i_push1);
    assign w_wr_ptr1   = r_wr_ptr + PW'(1);
    assign w_rd_ptr1   = r_rd_ptr + PW'(1);
    assign o_head      = r_mem[r_rd_ptr];
    assign o_head1     = r_mem[w_rd_ptr1];
    assign o_count     = r_count;
    assign o_count_nxt = i_flush ? '0 : (r_count + w_push_n - CW'(i_pop_n));

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop_n);
            r_count  <= o_count_nxt;
        end
    end

    // Entry storage; push0 is always the older of two same-cycle pushes.
    always_ff @(posedge clk) begin
        if (i_push0) r_mem[r_wr_ptr]  <= i_push0_dat;
        if (i_push1) r_mem[w_wr_ptr1] <= i_push1_dat;
    end

endmodule

// File: rtl/dc1_xbit_upd.sv
// X-bit array write sequencer: post-reset/barrier clear walk, insert path, 2-wide pipe request FIFO.
// Latency: request pushed in N writes in N+2; insert in N writes in N+1; walk takes 2*2^ADDR_WIDTH cycles.
// Backpressure: req_ready needs two free FIFO slots and RUN; ins_ready is high throughout RUN.
module dc1_xbit_upd
    import dc1_xbit_upd_pkg::*;
#(
    parameter int ADDR_WIDTH = XBIT_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH+4:0] req0_addr,
    input  logic                  req0_odd,
    input  logic                  req0_pbit,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH+4:0] req1_addr,
    input  logic                  req1_odd,
    input  logic                  req1_pbit,
    output logic                  req_ready,
    input  logic                  ins_valid,
    input  logic [ADDR_WIDTH+4:0] ins_addr,
    input  logic [15:0]           ins_data,
    output logic                  ins_ready,
    input  logic                  clr_all,
    output logic                  write0_clkEn,
    output logic [ADDR_WIDTH+4:0] write0_addr,
    output logic                  write0_odd,
    output logic                  write0_pbit,
    output logic                  write1_clkEn,
    output logic [ADDR_WIDTH+4:0] write1_addr,
    output logic                  write1_odd,
    output logic                  write1_pbit,
    output logic                  write_ins,
    output logic [15:0]           write_data,
    output logic                  busy
);
    localparam int                  CW        = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0] WALK_LAST = '1;

    xbit_state_e           r_state;
    logic [ADDR_WIDTH:0]   r_walk_cnt;
    logic                  r_w0_en, r_w0_odd, r_w0_pbit;
    logic                  r_w1_en, r_w1_odd, r_w1_pbit;
    logic [ADDR_WIDTH+4:0] r_w0_addr, r_w1_addr;
    logic                  r_wins;
    logic [15:0]           r_wdata;
    logic                  r_busy;

    xbit_req_t             w_req0, w_req1, w_push0_dat, w_head, w_head1;
    logic                  w_req_acc, w_ins_acc, w_push0, w_push1, w_merge;
    logic [1:0]            w_pop_n;
    logic [CW-1:0]         w_count, w_count_nxt;
    logic [ADDR_WIDTH+4:0] w_walk_addr;

    assign w_req0 = '{addr: req0_addr, odd: req0_odd, pbit: req0_pbit};
    assign w_req1 = '{addr: req1_addr, odd: req1_odd, pbit: req1_pbit};

    // Ready depends only on registered state, so senders see a clean level.
    assign req_ready = (r_state == ST_RUN) && (w_count <= CW'(DEPTH - 2));
    assign ins_ready = (r_state == ST_RUN);

    // A clear in the same cycle discards whatever is being offered.
    assign w_req_acc   = req_ready & ~clr_all;
    assign w_ins_acc   = ins_ready & ins_valid & ~clr_all;
    assign w_push0     = w_req_acc & (req0_valid | req1_valid);
    assign w_push1     = w_req_acc & req0_valid & req1_valid;
    assign w_push0_dat = req0_valid ? w_req0 : w_req1;

    // Walk entry cnt clears set cnt>>1, bank cnt[0]; all other address bits zero.
    assign w_walk_addr = {1'b0, r_walk_cnt[ADDR_WIDTH:1], 4'b0000};

    dc1_xbit_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (clr_all),
        .i_push0     (w_push0),
        .i_push0_dat (w_push0_dat),
        .i_push1     (w_push1),
        .i_push1_dat (w_req1),
        .i_pop_n     (w_pop_n),
        .o_head      (w_head),
        .o_head1     (w_head1),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt)
    );

    // Pop selection: inserts own port 0, otherwise drain up to two entries.
    always_comb begin
        w_pop_n = 2'd0;
        w_merge = 1'b0;
        if ((r_state == ST_RUN) && !clr_all && !w_ins_acc) begin
            if (w_count >= CW'(2)) begin
                w_pop_n = 2'd2;
                w_merge = xbit_same_slot(w_head, w_head1);
            end else if (w_count == CW'(1)) begin
                w_pop_n = 2'd1;
            end
        end
    end

    // Sequencer state and registered array-port drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_WALK;
            r_walk_cnt <= '0;
            r_w0_en    <= 1'b0;
            r_w0_addr  <= '0;
            r_w0_odd   <= 1'b0;
            r_w0_pbit  <= 1'b0;
            r_w1_en    <= 1'b0;
            r_w1_addr  <= '0;
            r_w1_odd   <= 1'b0;
            r_w1_pbit  <= 1'b0;
            r_wins     <= 1'b0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_w0_en   <= 1'b0;
            r_w0_addr <= '0;
            r_w0_odd  <= 1'b0;
            r_w0_pbit <= 1'b0;
            r_w1_en   <= 1'b0;
            r_w1_addr <= '0;
            r_w1_odd  <= 1'b0;
            r_w1_pbit <= 1'b0;
            r_wins    <= 1'b0;
            r_wdata   <= '0;
            if (clr_all) begin
                r_state    <= ST_WALK;
                r_walk_cnt <= '0;
                r_busy     <= 1'b1;
            end else if (r_state == ST_WALK) begin
                r_w0_en    <= 1'b1;
                r_wins     <= 1'b1;
                r_w0_addr  <= w_walk_addr;
                r_w0_odd   <= r_walk_cnt[0];
                r_walk_cnt <= r_walk_cnt + 1'b1;
                if (r_walk_cnt == WALK_LAST) begin
                    r_state <= ST_RUN;
                end
                r_busy <= (r_walk_cnt != WALK_LAST);
            end else begin
                if (w_ins_acc) begin
                    r_w0_en   <= 1'b1;
                    r_wins    <= 1'b1;
                    r_w0_addr <= ins_addr;
                    r_wdata   <= ins_data;
                end else if (w_pop_n != 2'd0) begin
                    r_w0_en <= 1'b1;
                    if (w_merge) begin
                        // Same bit twice: only the younger value reaches the array.
                        r_w0_addr <= w_head1.addr;
                        r_w0_odd  <= w_head1.odd;
                        r_w0_pbit <= w_head1.pbit;
                    end else begin
                        r_w0_addr <= w_head.addr;
                        r_w0_odd  <= w_head.odd;
                        r_w0_pbit <= w_head.pbit;
                        if (w_pop_n == 2'd2) begin
                            r_w1_en   <= 1'b1;
                            r_w1_addr <= w_head1.addr;
                            r_w1_odd  <= w_head1.odd;
                            r_w1_pbit <= w_head1.pbit;
                        end
                    end
                end
                r_busy <= (w_count_nxt != '0);
            end
        end
    end

    assign write0_clkEn = r_w0_en;
    assign write0_addr  = r_w0_addr;
    assign write0_odd   = r_w0_odd;
    assign write0_pbit  = r_w0_pbit;
    assign write1_clkEn = r_w1_en;
    assign write1_addr  = r_w1_addr;
    assign write1_odd   = r_w1_odd;
    assign write1_pbit  = r_w1_pbit;
    assign write_ins    = r_wins;
    assign write_data   = r_wdata;
    assign busy         = r_busy;

endmodule
